// File: rtl/countdown_timer_if.sv
// Control and display bundle for the hh:mm:ss countdown timer.
interface countdown_timer_if;
  localparam int unsigned FW = 7;

  logic          tick;
  logic          load;
  logic          start;
  logic          pause;
  logic [FW-1:0] init_hour;
  logic [FW-1:0] init_min;
  logic [FW-1:0] init_sec;
  logic [FW-1:0] hour;
  logic [FW-1:0] min;
  logic [FW-1:0] sec;
  logic          running;
  logic          expired;
  logic          done;

  modport master (
    output tick, load, start, pause, init_hour, init_min, init_sec,
    input  hour, min, sec, running, expired, done
  );

  modport slave (
    input  tick, load, start, pause, init_hour, init_min, init_sec,
    output hour, min, sec, running, expired, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Down-counting hh:mm:ss timer with a borrow chain and a load/start/pause control FSM.
module countdown_timer #(
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned MIN_MAX  = 59,
  parameter int unsigned SEC_MAX  = 59
) (
  input  logic              clk,
  input  logic              rst_n,
  countdown_timer_if.slave  bus
);
  localparam int unsigned FW = 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [FW-1:0] HOUR_LIM = FW'(HOUR_MAX);
  localparam logic [FW-1:0] MIN_LIM  = FW'(MIN_MAX);
  localparam logic [FW-1:0] SEC_LIM  = FW'(SEC_MAX);

  logic [1:0]    state, state_nxt;
  logic [FW-1:0] hour_q, min_q, sec_q;
  logic [FW-1:0] hour_nxt, min_nxt, sec_nxt;
  logic          running_q, expired_q, done_q;
  logic          running_nxt, expired_nxt, done_nxt;

  logic [FW-1:0] hour_sat, min_sat, sec_sat;
  logic [FW-1:0] hour_dec, min_dec, sec_dec;
  logic          borrow_s, borrow_m;
  logic          count_nz, count_one;

  // Load values clamp to each field's maximum.
  assign hour_sat = (bus.init_hour > HOUR_LIM) ? HOUR_LIM : bus.init_hour;
  assign min_sat  = (bus.init_min  > MIN_LIM)  ? MIN_LIM  : bus.init_min;
  assign sec_sat  = (bus.init_sec  > SEC_LIM)  ? SEC_LIM  : bus.init_sec;

  // Borrow chain: all fields resolve combinationally and update on one edge.
  assign borrow_s = (sec_q == '0);
  assign borrow_m = borrow_s && (min_q == '0);
  assign sec_dec  = borrow_s ? SEC_LIM : (sec_q - FW'(1));
  assign min_dec  = borrow_s ? ((min_q == '0) ? MIN_LIM : (min_q - FW'(1))) : min_q;
  assign hour_dec = borrow_m ? (hour_q - FW'(1)) : hour_q;

  assign count_nz  = (hour_q != '0) || (min_q != '0) || (sec_q != '0);
  assign count_one = (hour_q == '0) && (min_q == '0) && (sec_q == FW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hour_q    <= hour_nxt;
      min_q     <= min_nxt;
      sec_q     <= sec_nxt;
      running_q <= running_nxt;
      expired_q <= expired_nxt;
      done_q    <= done_nxt;
    end
  end

  // Next state and next count; priority load > pause > start > tick.
  always_comb begin
    state_nxt = state;
    hour_nxt  = hour_q;
    min_nxt   = min_q;
    sec_nxt   = sec_q;
    done_nxt  = 1'b0;

    if (bus.load) begin
      state_nxt = S_IDLE;
      hour_nxt  = hour_sat;
      min_nxt   = min_sat;
      sec_nxt   = sec_sat;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && count_nz) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (bus.pause) begin
            state_nxt = S_PAUSE;
          end else if (bus.tick) begin
            hour_nxt = hour_dec;
            min_nxt  = min_dec;
            sec_nxt  = sec_dec;
            if (count_one) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (bus.start) state_nxt = S_RUN;
        end
        default: begin
          state_nxt = S_DONE;
        end
      endcase
    end

    running_nxt = (state_nxt == S_RUN);
    expired_nxt = (state_nxt == S_DONE);
  end

  assign bus.hour    = hour_q;
  assign bus.min     = min_q;
  assign bus.sec     = sec_q;
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Vector-table and scoreboard bench for countdown_timer.
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  countdown_timer_if bus();

  countdown_timer #(
    .HOUR_MAX(23),
    .MIN_MAX (59),
    .SEC_MAX (59)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       ld;
    logic [6:0] ih, im, is;
    logic       st, pa, tk;
    logic [6:0] eh, em, es;
    logic       er, ex, ed;
  } vec_t;

  typedef struct {
    logic [6:0] h, m, s;
    logic       r, x, d;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic ld, input int ih, input int im, input int is,
                              input logic st, input logic pa, input logic tk,
                              input int eh, input int em, input int es,
                              input logic er, input logic ex, input logic ed);
    vec_t v;
    v.ld = ld; v.ih = 7'(ih); v.im = 7'(im); v.is = 7'(is);
    v.st = st; v.pa = pa; v.tk = tk;
    v.eh = 7'(eh); v.em = 7'(em); v.es = 7'(es);
    v.er = er; v.ex = ex; v.ed = ed;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic ld, input logic [6:0] ih, input logic [6:0] im,
                       input logic [6:0] is, input logic st, input logic pa, input logic tk);
    bus.load = ld; bus.init_hour = ih; bus.init_min = im; bus.init_sec = is;
    bus.start = st; bus.pause = pa; bus.tick = tk;
  endtask

  task automatic push_exp(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s,
                          input logic r, input logic x, input logic d, input int tag);
    exp_t e;
    e.h = h; e.m = m; e.s = s; e.r = r; e.x = x; e.d = d; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got output with no expected entry");
    end else begin
      e = sb.pop_front();
      if (bus.hour !== e.h || bus.min !== e.m || bus.sec !== e.s ||
          bus.running !== e.r || bus.expired !== e.x || bus.done !== e.d) begin
        bad++;
        $display("FAIL step%0d: got %0d:%0d:%0d run=%b exp=%b done=%b, want %0d:%0d:%0d run=%b exp=%b done=%b",
                 e.tag, bus.hour, bus.min, bus.sec, bus.running, bus.expired, bus.done,
                 e.h, e.m, e.s, e.r, e.x, e.d);
      end
    end
  endtask

  task automatic cycle(input logic ld, input int ih, input int im, input int is,
                       input logic st, input logic pa, input logic tk,
                       input int eh, input int em, input int es,
                       input logic er, input logic ex, input logic ed, input int tag);
    drive(ld, 7'(ih), 7'(im), 7'(is), st, pa, tk);
    push_exp(7'(eh), 7'(em), 7'(es), er, ex, ed, tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: 00:00:03 countdown to expiry, DONE is sticky
    add(1, 0, 0, 3,  0, 0, 0,  0, 0, 3,  0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0,  0, 0, 3,  1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0, 2,  1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0, 1,  1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0, 0,  0, 1, 1);
    add(0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0, 0,  0, 1, 0);
    add(0, 0, 0, 0,  1, 0, 0,  0, 0, 0,  0, 1, 0);
    add(0, 0, 0, 0,  0, 1, 0,  0, 0, 0,  0, 1, 0);
    // 2: full borrow chain 01:00:00 -> 00:59:59
    add(1, 1, 0, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 59, 59, 1, 0, 0);
    // 3: pause beats tick, ticks ignored while paused, resume
    add(1, 0, 10, 5, 0, 0, 0,  0, 10, 5, 0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0,  0, 10, 5, 1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 10, 4, 1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 10, 3, 1, 0, 0);
    add(0, 0, 0, 0,  0, 1, 1,  0, 10, 3, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 10, 3, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 10, 3, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 10, 3, 0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0,  0, 10, 3, 1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 10, 2, 1, 0, 0);
    // 4: saturating load, start on zero count stays idle
    add(1, 30, 75, 60, 0, 0, 0, 23, 59, 59, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0,  0, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0, 0,  0, 0, 0);
    // 5: load beats tick mid-run
    add(1, 0, 0, 5,  0, 0, 0,  0, 0, 5,  0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0,  0, 0, 5,  1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0, 4,  1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0, 3,  1, 0, 0);
    add(1, 0, 2, 0,  0, 0, 1,  0, 2, 0,  0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0,  0, 2, 0,  1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 1, 59, 1, 0, 0);

    rst_n = 1'b0;
    drive(0, '0, '0, '0, 0, 0, 0);
    #3;
    push_exp('0, '0, '0, 0, 0, 0, 1000);
    check_pop();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp('0, '0, '0, 0, 0, 0, 1001);
    check_pop();

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].ih, vecs[i].im, vecs[i].is, vecs[i].st, vecs[i].pa, vecs[i].tk);
      push_exp(vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].er, vecs[i].ex, vecs[i].ed, i);
      @(posedge clk);
      #1;
      check_pop();
    end

    // 6: asynchronous reset between edges aborts the count
    cycle(1, 0, 0, 2,  0, 0, 0,  0, 0, 2,  0, 0, 0, 2000);
    cycle(0, 0, 0, 0,  1, 0, 0,  0, 0, 2,  1, 0, 0, 2001);
    drive(0, '0, '0, '0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    push_exp('0, '0, '0, 0, 0, 0, 2002);
    check_pop();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      push_exp('0, '0, '0, 0, 0, 0, 2003 + k);
      check_pop();
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0,  1, 0, 0,  0, 0, 0,  0, 0, 0, 2010);
    // expiry straight from 00:00:01
    cycle(1, 0, 0, 1,  0, 0, 0,  0, 0, 1,  0, 0, 0, 2011);
    cycle(0, 0, 0, 0,  1, 0, 0,  0, 0, 1,  1, 0, 0, 2012);
    cycle(0, 0, 0, 0,  0, 0, 1,  0, 0, 0,  0, 1, 1, 2013);
    cycle(0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 2014);
    // load from DONE returns to IDLE
    cycle(1, 5, 6, 7,  0, 0, 0,  5, 6, 7,  0, 0, 0, 2015);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
